// File: rtl/axis_dest_classifier.sv
// AXI-Stream per-packet tdest tagger with registered output and skid buffer.
// Optional `AXIS_DEST_CLASSIFIER_DROP_EN: drop packets whose selector is out of range, adds drop_pulse.
`timescale 1ns/1ps
module axis_dest_classifier #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_DESTS      = 2,
    parameter int SEL_BYTE       = 0,
    parameter int DEFAULT_DEST   = 0,
    localparam int DEST_BITS     = (NUM_DESTS == 1) ? 1 : $clog2(NUM_DESTS)
) (
    input  logic                      clk,
    input  logic                      sreset,
    output logic                      axis_i_tready,
    input  logic                      axis_i_tvalid,
    input  logic                      axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]   axis_i_tdata,
    input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
    input  logic                      axis_o_tready,
    output logic                      axis_o_tvalid,
    output logic                      axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
    output logic                      drop_pulse,
`endif
    output logic [DEST_BITS-1:0]      axis_o_tdest
);

    localparam int DW = AXIS_BYTES * 8;
    localparam int PW = 1 + AXIS_USER_BITS + DW + DEST_BITS;

`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
    typedef enum logic [1:0] {HEAD, BODY, DROP} state_t;
`else
    typedef enum logic [0:0] {HEAD, BODY} state_t;
`endif

    state_t               state, state_nxt;
    logic [DEST_BITS-1:0] cur_dest, head_dest, tag_dest;
    logic [7:0]           sel;
    logic                 in_range, in_fire, drop_beat, push;
    logic                 in_ready, out_valid, skid_valid;
    logic [PW-1:0]        in_beat, out_beat, skid_beat;

    assign axis_i_tready = in_ready;
    assign in_fire       = axis_i_tvalid && in_ready;
    assign sel           = axis_i_tdata[8*SEL_BYTE +: 8];
    // full 8-bit compare so e.g. sel=0x04 never aliases onto dest 0
    assign in_range      = 32'(sel) < 32'(NUM_DESTS);
    assign head_dest     = in_range ? DEST_BITS'(sel) : DEST_BITS'(DEFAULT_DEST);
    assign push          = in_fire && !drop_beat;
    assign in_beat       = {axis_i_tlast, axis_i_tuser, axis_i_tdata, tag_dest};

    always_comb begin
        state_nxt = state;
        tag_dest  = cur_dest;
        drop_beat = 1'b0;
        case (state)
            HEAD: begin
                tag_dest = head_dest;
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
                drop_beat = !in_range;
                if (in_fire && !axis_i_tlast)
                    state_nxt = in_range ? BODY : DROP;
`else
                if (in_fire && !axis_i_tlast)
                    state_nxt = BODY;
`endif
            end
            BODY: begin
                if (in_fire && axis_i_tlast)
                    state_nxt = HEAD;
            end
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
            DROP: begin
                drop_beat = 1'b1;
                if (in_fire && axis_i_tlast)
                    state_nxt = HEAD;
            end
`endif
            default: state_nxt = HEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state    <= HEAD;
            cur_dest <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire && state == HEAD)
                cur_dest <= head_dest;
        end
    end

    // Output register backed by one skid slot; ready depends only on next skid occupancy.
    always_ff @(posedge clk) begin
        if (sreset) begin
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_beat   <= '0;
            skid_beat  <= '0;
        end else begin
            if (!out_valid || axis_o_tready) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_beat   <= skid_beat;
                    skid_valid <= push;
                    if (push)
                        skid_beat <= in_beat;
                end else begin
                    out_valid <= push;
                    if (push)
                        out_beat <= in_beat;
                end
            end else if (push) begin
                skid_valid <= 1'b1;
                skid_beat  <= in_beat;
            end
            in_ready <= !((out_valid && !axis_o_tready) ? (skid_valid || push)
                                                        : (skid_valid && push));
        end
    end

`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
    always_ff @(posedge clk) begin
        if (sreset)
            drop_pulse <= 1'b0;
        else
            drop_pulse <= in_fire && drop_beat && axis_i_tlast;
    end
`endif

    assign axis_o_tvalid = out_valid;
    assign {axis_o_tlast, axis_o_tuser, axis_o_tdata, axis_o_tdest} = out_beat;

endmodule

// File: tb/tb_axis_dest_classifier.sv
// Self-checking bench for axis_dest_classifier: randomized traffic against a packet-level model.
`timescale 1ns/1ps
module tb_axis_dest_classifier;

    localparam int AXIS_BYTES   = 2;
    localparam int USER_BITS    = 2;
    localparam int NUM_DESTS    = 4;
    localparam int SEL_BYTE     = 0;
    localparam int DEFAULT_DEST = 1;

    logic        clk = 1'b0;
    logic        sreset = 1'b1;
    logic        i_ready, i_valid = 1'b0, i_last = 1'b0;
    logic [15:0] i_data = '0;
    logic [1:0]  i_user = '0;
    logic        o_ready = 1'b0, o_valid, o_last;
    logic [15:0] o_data;
    logic [1:0]  o_user, o_tdest;
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
    logic        drop_pulse;
`endif

    always #5 clk = ~clk;

    axis_dest_classifier #(
        .AXIS_BYTES(AXIS_BYTES), .AXIS_USER_BITS(USER_BITS), .NUM_DESTS(NUM_DESTS),
        .SEL_BYTE(SEL_BYTE), .DEFAULT_DEST(DEFAULT_DEST)
    ) dut (
        .clk(clk), .sreset(sreset),
        .axis_i_tready(i_ready), .axis_i_tvalid(i_valid), .axis_i_tlast(i_last),
        .axis_i_tdata(i_data), .axis_i_tuser(i_user),
        .axis_o_tready(o_ready), .axis_o_tvalid(o_valid), .axis_o_tlast(o_last),
        .axis_o_tdata(o_data), .axis_o_tuser(o_user),
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
        .drop_pulse(drop_pulse),
`endif
        .axis_o_tdest(o_tdest)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  user;
        logic        last;
        logic [1:0]  dest;
        logic        drop;
    } beat_t;

    beat_t drv_q[$];
    beat_t exp_q[$];
    int    tests = 0, fails = 0, held = 0, cyc = 0;
    bit    in_fire = 0, out_fire = 0, exp_pulse = 0;

    // Packet-level rule: destination from head selector, -1 means dropped.
    function automatic int classify(input logic [7:0] sel);
        if (int'(sel) < NUM_DESTS) return int'(sel);
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
        return -1;
`else
        return DEFAULT_DEST;
`endif
    endfunction

    task automatic add_pkt(input int len, input logic [7:0] sel);
        int    d;
        beat_t b;
        d = classify(sel);
        for (int i = 0; i < len; i++) begin
            b.data = 16'($urandom);
            if (i == 0) b.data[7:0] = sel;
            b.user = 2'($urandom);
            b.last = (i == len - 1);
            b.drop = (d < 0);
            b.dest = (d < 0) ? 2'd0 : 2'(d);
            drv_q.push_back(b);
            if (!b.drop) exp_q.push_back(b);
        end
    endtask

    // One cycle of driving: retires the previous cycle's handshakes, then
    // decides this cycle's stimulus and which transfers will occur at the next edge.
    task automatic step(input int ready_pct, input int valid_pct);
        @(negedge clk);
        exp_pulse = 0;
        if (in_fire) begin
            if (!drv_q[0].drop) held++;
            exp_pulse = drv_q[0].drop && drv_q[0].last;
            drv_q.delete(0);
        end
        if (out_fire) held--;
        cyc++;
        o_ready = ($urandom_range(99) < ready_pct);
        if (!i_valid || in_fire) begin
            if (drv_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                i_valid = 1'b1;
                i_data  = drv_q[0].data;
                i_user  = drv_q[0].user;
                i_last  = drv_q[0].last;
            end else begin
                i_valid = 1'b0;
            end
        end
        in_fire  = i_valid && i_ready;
        out_fire = o_valid && o_ready;
    endtask

    task automatic clear_model();
        drv_q.delete();
        exp_q.delete();
        held = 0; in_fire = 0; out_fire = 0; exp_pulse = 0;
    endtask

    task automatic test_reset();
        sreset = 1'b1; i_valid = 1'b1; i_data = 16'h0102; o_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b want 0", o_valid); end
            tests++; if (i_ready !== 1'b0) begin fails++; $display("FAIL reset_tready: got %b want 0", i_ready); end
        end
        sreset = 1'b0; i_valid = 1'b0;
        clear_model();
        @(negedge clk);
        tests++; if (i_ready !== 1'b1) begin fails++; $display("FAIL post_reset_tready: got %b want 1", i_ready); end
        tests++; if ({o_valid, o_last, o_data, o_user, o_tdest} !== 22'd0) begin
            fails++; $display("FAIL post_reset_outputs: got %h want 0", {o_valid, o_last, o_data, o_user, o_tdest});
        end
        repeat (3) step(100, 0);
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL idle_no_output: got %b want 0", o_valid); end
    endtask

    task automatic test_single_packet();
        int    first_acc = -1, first_out = -1;
        beat_t e;
        add_pkt(3, 8'h02);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            step(100, 100);
            if (in_fire && first_acc < 0) first_acc = cyc;
            if (o_valid && first_out < 0) first_out = cyc;
            if (out_fire) begin
                e = exp_q.pop_front();
                tests++; if ({o_last, o_user, o_data, o_tdest} !== {e.last, e.user, e.data, e.dest}) begin
                    fails++; $display("FAIL single_beat: got %h want %h", {o_last, o_user, o_data, o_tdest}, {e.last, e.user, e.data, e.dest});
                end
                tests++; if (o_tdest !== 2'd2) begin fails++; $display("FAIL single_tdest: got %0d want 2", o_tdest); end
            end
        end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL single_timeout: %0d beats missing want 0", exp_q.size()); end
        tests++; if (first_out != first_acc + 1) begin
            fails++; $display("FAIL single_latency: out cycle %0d want %0d", first_out, first_acc + 1);
        end
    endtask

    task automatic test_back_to_back();
        int    outs[$];
        beat_t e;
        logic [1:0] want[3] = '{2'd0, 2'd3, 2'd1};
        add_pkt(1, 8'h00); add_pkt(1, 8'h03); add_pkt(1, 8'h01);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            step(100, 100);
            if (out_fire) begin
                e = exp_q.pop_front();
                tests++; if ({o_last, o_user, o_data, o_tdest} !== {e.last, e.user, e.data, e.dest}) begin
                    fails++; $display("FAIL b2b_beat: got %h want %h", {o_last, o_user, o_data, o_tdest}, {e.last, e.user, e.data, e.dest});
                end
                if (outs.size() < 3) begin
                    tests++; if (o_tdest !== want[outs.size()]) begin
                        fails++; $display("FAIL b2b_tdest: got %0d want %0d", o_tdest, want[outs.size()]);
                    end
                end
                outs.push_back(cyc);
            end
        end
        tests++; if (outs.size() != 3 || outs[2] - outs[0] != 2) begin
            fails++; $display("FAIL b2b_bubbles: got %0d beats spanning %0d cycles want 3 beats over 2", outs.size(), (outs.size() == 3) ? outs[2] - outs[0] : -1);
        end
    endtask

    task automatic test_out_of_range();
        int    pulses = 0, n_def = 0;
        beat_t e;
        add_pkt(2, 8'h04);
        add_pkt(1, 8'h03);
        for (int c = 0; c < 40 && (drv_q.size() > 0 || exp_q.size() > 0 || in_fire); c++) begin
            step(100, 100);
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
            tests++; if (drop_pulse !== exp_pulse) begin fails++; $display("FAIL oor_drop_pulse: got %b want %b", drop_pulse, exp_pulse); end
            if (drop_pulse) pulses++;
`endif
            if (out_fire) begin
                e = exp_q.pop_front();
                tests++; if ({o_last, o_user, o_data, o_tdest} !== {e.last, e.user, e.data, e.dest}) begin
                    fails++; $display("FAIL oor_beat: got %h want %h", {o_last, o_user, o_data, o_tdest}, {e.last, e.user, e.data, e.dest});
                end
                if (o_tdest == 2'(DEFAULT_DEST)) n_def++;
            end
        end
        tests++; if (exp_q.size() != 0 || drv_q.size() != 0) begin fails++; $display("FAIL oor_timeout: %0d beats left want 0", exp_q.size() + drv_q.size()); end
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
        tests++; if (pulses != 1) begin fails++; $display("FAIL oor_pulse_count: got %0d want 1", pulses); end
`else
        tests++; if (n_def != 2) begin fails++; $display("FAIL oor_default_dest: got %0d beats want 2", n_def); end
`endif
    endtask

    task automatic test_reset_mid();
        bit    first = 1;
        beat_t e;
        add_pkt(4, 8'h02);
        for (int c = 0; c < 20 && held != 2; c++) step(0, 100);
        tests++; if (held != 2) begin fails++; $display("FAIL midrst_fill: held %0d want 2", held); end
        sreset = 1'b1; o_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL midrst_tvalid: got %b want 0", o_valid); end
            tests++; if (i_ready !== 1'b0) begin fails++; $display("FAIL midrst_tready: got %b want 0", i_ready); end
        end
        sreset = 1'b0; i_valid = 1'b0;
        clear_model();
        add_pkt(2, 8'h01);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            step(100, 100);
            if (out_fire) begin
                e = exp_q.pop_front();
                tests++; if ({o_last, o_user, o_data, o_tdest} !== {e.last, e.user, e.data, e.dest}) begin
                    fails++; $display("FAIL midrst_beat: got %h want %h", {o_last, o_user, o_data, o_tdest}, {e.last, e.user, e.data, e.dest});
                end
                if (first) begin
                    tests++; if (o_tdest !== 2'd1) begin fails++; $display("FAIL midrst_tdest: got %0d want 1", o_tdest); end
                    first = 0;
                end
            end
        end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL midrst_timeout: %0d beats missing want 0", exp_q.size()); end
    endtask

    task automatic test_random();
        int    total = 0, len;
        logic [7:0] sel;
        beat_t e;
        while (total < 1000) begin
            len = $urandom_range(1, 5);
            sel = ($urandom_range(1) == 0) ? 8'($urandom_range(5)) : 8'($urandom);
            add_pkt(len, sel);
            total += len;
        end
        for (int c = 0; c < 20000 && (drv_q.size() > 0 || exp_q.size() > 0 || in_fire); c++) begin
            step(50, 80);
            tests++; if (i_ready !== (held < 2)) begin fails++; $display("FAIL rand_tready: got %b want %b (held %0d)", i_ready, held < 2, held); end
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
            tests++; if (drop_pulse !== exp_pulse) begin fails++; $display("FAIL rand_drop_pulse: got %b want %b", drop_pulse, exp_pulse); end
`endif
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++; $display("FAIL rand_extra_beat: got %h want none", {o_last, o_user, o_data, o_tdest});
                end else begin
                    e = exp_q.pop_front();
                    tests++; if ({o_last, o_user, o_data, o_tdest} !== {e.last, e.user, e.data, e.dest}) begin
                        fails++; $display("FAIL rand_beat: got %h want %h", {o_last, o_user, o_data, o_tdest}, {e.last, e.user, e.data, e.dest});
                    end
                end
            end
        end
        tests++; if (exp_q.size() != 0 || drv_q.size() != 0) begin fails++; $display("FAIL rand_timeout: %0d beats left want 0", exp_q.size() + drv_q.size()); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
